// File: rtl/servo_ramp.sv
// servo_ramp: slew-rate-limited servo on-time generator with target handshake
module servo_ramp #(
  parameter int W = 15,
  parameter logic [W-1:0] MIN_T = 15'h1770,
  parameter logic [W-1:0] MAX_T = 15'h5dc0,
  parameter logic [W-1:0] DEF_T = 15'h3a98,
  parameter int DIV_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] tgt_i,
  input  logic [7:0]   step_i,
  input  logic         tgt_vld_i,
  output logic         tgt_rdy_o,
  output logic [W-1:0] on_t_o,
  output logic         busy_o,
  output logic         done_o
);
  typedef enum logic {IDLE, RAMP} state_t;
  state_t state, state_n;
  logic [W-1:0] tgt_r, tgt_c, on_t_n, stp;
  logic [7:0] step_r;
  logic [DIV_W-1:0] cnt;
  logic [W:0] diff;
  logic tick, acc, fin, up, done_n;
  assign tick = &cnt;
  assign tgt_rdy_o = (state == IDLE) && !rst;
  assign acc = tgt_vld_i && tgt_rdy_o;
  assign busy_o = state == RAMP;
  assign tgt_c = tgt_i < MIN_T ? MIN_T : tgt_i > MAX_T ? MAX_T : tgt_i;
  assign up = tgt_r > on_t_o;
  assign diff = up ? {1'b0, tgt_r} - {1'b0, on_t_o} : {1'b0, on_t_o} - {1'b0, tgt_r};
  assign stp = {{(W-8){1'b0}}, step_r};
  assign fin = diff <= {1'b0, stp};
  // next state and on-time: move only on tick while ramping, snap to target when within one step
  always_comb begin
    state_n = state == IDLE ? (acc ? RAMP : IDLE) : (tick && fin ? IDLE : RAMP);
    done_n = state == RAMP && tick && fin;
    on_t_n = state == RAMP && tick ? (fin ? tgt_r : up ? on_t_o + stp : on_t_o - stp) : on_t_o;
  end
  // state, on-time, tick divider and captured target/step registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      on_t_o <= DEF_T;
      done_o <= 1'b0;
      cnt <= '0;
      tgt_r <= DEF_T;
      step_r <= 8'd1;
    end else begin
      state <= state_n;
      on_t_o <= on_t_n;
      done_o <= done_n;
      cnt <= cnt + 1'b1;
      if (acc) begin
        tgt_r <= tgt_c;
        step_r <= step_i == 8'd0 ? 8'd1 : step_i;
      end
    end
  end
endmodule

// File: tb/tb_servo_ramp.sv
// tb_servo_ramp: directed self-checking bench for servo_ramp with a 16-cycle tick
module tb_servo_ramp;
  logic clk = 0, rst = 1, vld = 0, rdy, busy, done;
  logic [14:0] tgt = 0, on_t;
  logic [7:0] step = 0;
  int checks = 0, errors = 0;

  servo_ramp #(.DIV_W(4)) dut (
    .clk(clk), .rst(rst), .tgt_i(tgt), .step_i(step), .tgt_vld_i(vld),
    .tgt_rdy_o(rdy), .on_t_o(on_t), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_ramp(input string name, input logic [14:0] t, input logic [7:0] s,
                         input logic [14:0] fin_exp, input int moves_exp, output int ncyc);
    logic [14:0] prev, exp_v, d, se;
    int gap, moves, bad_val, bad_gap, bad_rdy;
    bit first, seen;
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL %s rdy_before got %b want 1", name, rdy); end
    tgt = t; step = s; vld = 1;
    cyc;
    vld = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_accept got %b want 1", name, busy); end
    se = (s == 0) ? 15'd1 : {7'd0, s};
    prev = on_t; gap = 0; moves = 0; bad_val = 0; bad_gap = 0; bad_rdy = 0; first = 1; seen = 0; ncyc = 0;
    for (int i = 0; i < 20000; i++) begin
      cyc;
      gap++; ncyc++;
      if (on_t !== prev) begin
        moves++;
        d = fin_exp > prev ? fin_exp - prev : prev - fin_exp;
        exp_v = d <= se ? fin_exp : fin_exp > prev ? prev + se : prev - se;
        if (on_t !== exp_v) begin
          bad_val++;
          $display("FAIL %s step_value got %0d want %0d", name, on_t, exp_v);
        end
        if (first ? gap > 16 : gap != 16) bad_gap++;
        first = 0; gap = 0; prev = on_t;
      end
      if (done === 1'b1) begin seen = 1; break; end
      if (rdy !== 1'b0) bad_rdy++;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s done_timeout got 0 want 1", name); end
    checks++;
    if (on_t !== fin_exp) begin errors++; $display("FAIL %s final got %0d want %0d", name, on_t, fin_exp); end
    checks++;
    if (moves != moves_exp) begin errors++; $display("FAIL %s moves got %0d want %0d", name, moves, moves_exp); end
    checks++;
    if (bad_val != 0) begin errors++; $display("FAIL %s values got %0d bad want 0", name, bad_val); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL %s tick_spacing got %0d bad want 0", name, bad_gap); end
    checks++;
    if (bad_rdy != 0) begin errors++; $display("FAIL %s rdy_during_ramp got %0d bad want 0", name, bad_rdy); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", name, busy); end
    cyc;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_width got %b want 0", name, done); end
    checks++;
    if (rdy !== 1'b1 || on_t !== fin_exp) begin
      errors++; $display("FAIL %s idle_after got rdy=%b on_t=%0d want rdy=1 on_t=%0d", name, rdy, on_t, fin_exp);
    end
  endtask

  task automatic test_reset;
    int done_seen, bad;
    rst = 1; vld = 0;
    cyc; cyc;
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL reset rdy_in_rst got %b want 0", rdy); end
    checks++;
    if (on_t !== 15'd15000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset values got on_t=%0d busy=%b done=%b want 15000 0 0", on_t, busy, done);
    end
    rst = 0;
    done_seen = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      cyc;
      if (done !== 1'b0) done_seen++;
      if (on_t !== 15'd15000 || busy !== 1'b0 || rdy !== 1'b1) bad++;
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL reset done_idle got %0d want 0", done_seen); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset hold got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_small_ramp;
    int n;
    do_ramp("small", 15'd15100, 8'd25, 15'd15100, 4, n);
  endtask

  task automatic test_clamp_high;
    int n;
    do_ramp("clamp_hi", 15'd30000, 8'd255, 15'd24000, 35, n);
  endtask

  task automatic test_step_zero;
    logic [14:0] want;
    int got;
    tgt = 15'd0; step = 8'd0; vld = 1;
    cyc;
    vld = 0;
    for (int k = 1; k <= 3; k++) begin
      want = 15'd24000 - 15'(k);
      got = 0;
      for (int i = 0; i < 40 && got == 0; i++) begin
        cyc;
        if (on_t !== want + 15'd1) got = 1;
      end
      checks++;
      if (on_t !== want) begin errors++; $display("FAIL step0 dec%0d got %0d want %0d", k, on_t, want); end
    end
    rst = 1;
    cyc;
    rst = 0;
    cyc;
    checks++;
    if (on_t !== 15'd15000 || busy !== 1'b0) begin
      errors++; $display("FAIL step0 reset got on_t=%0d busy=%b want 15000 0", on_t, busy);
    end
  endtask

  task automatic test_clamp_low;
    int n;
    do_ramp("clamp_lo", 15'd0, 8'd255, 15'd6000, 36, n);
  endtask

  task automatic test_same_target;
    int n;
    do_ramp("same", 15'd6000, 8'd40, 15'd6000, 0, n);
    checks++;
    if (n > 16) begin errors++; $display("FAIL same busy_len got %0d want <=16", n); end
  endtask

  task automatic test_rst_mid;
    bit hit;
    int bad;
    tgt = 15'd24000; step = 8'd250; vld = 1;
    cyc;
    vld = 0;
    hit = 0;
    for (int i = 0; i < 700 && !hit; i++) begin
      cyc;
      if (on_t === 15'd16000) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_mid reach16000 got %0d want 16000", on_t); end
    rst = 1;
    cyc;
    checks++;
    if (on_t !== 15'd15000 || busy !== 1'b0 || done !== 1'b0 || rdy !== 1'b0) begin
      errors++; $display("FAIL rst_mid after got on_t=%0d busy=%b done=%b rdy=%b want 15000 0 0 0", on_t, busy, done, rdy);
    end
    rst = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      cyc;
      if (on_t !== 15'd15000 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_mid no_resume got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    test_reset;
    test_small_ramp;
    test_clamp_high;
    test_step_zero;
    test_clamp_low;
    test_same_target;
    test_rst_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
